// File: rtl/mem_responder_if.sv
// Strobe/data bundle between the CPU control unit (master) and the memory responder (slave).
// Level strobes are held by the master; Ready holds until both strobes drop.
interface mem_responder_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 9
);
    logic              Read;
    logic              Write;
    logic [ADDR_W-1:0] Address;
    logic [DATA_W-1:0] DataIn;
    logic [DATA_W-1:0] DataOut;
    logic              Ready;
    logic              Busy;
    logic              Conflict;
    logic              AddrErr;

    modport master (
        output Read, Write, Address, DataIn,
        input  DataOut, Ready, Busy, Conflict, AddrErr
    );

    modport slave (
        input  Read, Write, Address, DataIn,
        output DataOut, Ready, Busy, Conflict, AddrErr
    );
endinterface

// File: rtl/mem_responder.sv
// Word RAM behind MAR/MDR; serves one Read/Write after WAIT_STATES wait cycles, Ready WAIT_STATES+1 edges after accept.
// Ready holds until both strobes drop; strobe/data changes after accept are ignored.
module mem_responder #(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 9,
    parameter int DEPTH       = 512,
    parameter int WAIT_STATES = 1
) (
    input logic             Clock,
    input logic             Reset,
    mem_responder_if.slave  bus
);

    localparam int              MEM_AW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);
    localparam logic [3:0]      WAIT_L  = 4'(WAIT_STATES);

    if (WAIT_STATES < 0 || WAIT_STATES > 15) begin : g_bad_wait
        $error("mem_responder: WAIT_STATES must be in 0..15");
    end
    if (DEPTH < 1 || DEPTH > (2 ** ADDR_W)) begin : g_bad_depth
        $error("mem_responder: DEPTH must be in 1..2**ADDR_W");
    end

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_ACCESS,
        S_HOLD
    } state_t;

    state_t              r_state;
    logic [3:0]          r_cnt;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_data;
    logic                r_wr;
    logic [DATA_W-1:0]   r_dout;
    logic                r_ready;
    logic                r_busy;
    logic                r_conflict;
    logic                r_addrerr;
    logic [DATA_W-1:0]   r_mem [DEPTH];

    state_t              w_state_nxt;
    logic [3:0]          w_cnt_nxt;
    logic [ADDR_W-1:0]   w_addr_nxt;
    logic [DATA_W-1:0]   w_data_nxt;
    logic                w_wr_nxt;
    logic [DATA_W-1:0]   w_dout_nxt;
    logic                w_ready_nxt;
    logic                w_busy_nxt;
    logic                w_conflict_nxt;
    logic                w_addrerr_nxt;
    logic                w_mem_we;
    logic                w_in_range;
    logic [MEM_AW-1:0]   w_idx;
    logic [DATA_W-1:0]   w_rd_word;

    assign w_in_range = ({1'b0, r_addr} < DEPTH_L);
    assign w_idx      = r_addr[MEM_AW-1:0];
    assign w_rd_word  = r_mem[w_idx];

    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_addr     <= '0;
            r_data     <= '0;
            r_wr       <= 1'b0;
            r_dout     <= '0;
            r_ready    <= 1'b0;
            r_busy     <= 1'b0;
            r_conflict <= 1'b0;
            r_addrerr  <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_addr     <= w_addr_nxt;
            r_data     <= w_data_nxt;
            r_wr       <= w_wr_nxt;
            r_dout     <= w_dout_nxt;
            r_ready    <= w_ready_nxt;
            r_busy     <= w_busy_nxt;
            r_conflict <= w_conflict_nxt;
            r_addrerr  <= w_addrerr_nxt;
        end
    end

    // RAM survives reset; the write enable is already gated by Reset.
    always_ff @(posedge Clock) begin
        if (w_mem_we) begin
            r_mem[w_idx] <= r_data;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_cnt_nxt      = r_cnt;
        w_addr_nxt     = r_addr;
        w_data_nxt     = r_data;
        w_wr_nxt       = r_wr;
        w_dout_nxt     = r_dout;
        w_ready_nxt    = r_ready;
        w_busy_nxt     = r_busy;
        w_conflict_nxt = r_conflict;
        w_addrerr_nxt  = r_addrerr;
        w_mem_we       = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (bus.Read ^ bus.Write) begin
                    w_addr_nxt     = bus.Address;
                    w_data_nxt     = bus.DataIn;
                    w_wr_nxt       = bus.Write;
                    w_cnt_nxt      = WAIT_L;
                    w_busy_nxt     = 1'b1;
                    w_conflict_nxt = 1'b0;
                    w_state_nxt    = (WAIT_L != 4'd0) ? S_WAIT : S_ACCESS;
                end else begin
                    w_conflict_nxt = bus.Read & bus.Write;
                end
            end

            S_WAIT: begin
                w_cnt_nxt = r_cnt - 4'd1;
                if (r_cnt <= 4'd1) begin
                    w_state_nxt = S_ACCESS;
                end
            end

            S_ACCESS: begin
                w_addrerr_nxt = ~w_in_range;
                if (r_wr) begin
                    w_mem_we = w_in_range & ~Reset;
                end else begin
                    w_dout_nxt = w_in_range ? w_rd_word : '0;
                end
                w_ready_nxt = 1'b1;
                w_busy_nxt  = 1'b0;
                w_state_nxt = S_HOLD;
            end

            S_HOLD: begin
                // A held strobe must not start a second access.
                if (!bus.Read && !bus.Write) begin
                    w_ready_nxt = 1'b0;
                    w_state_nxt = S_IDLE;
                end
            end

            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign bus.DataOut  = r_dout;
    assign bus.Ready    = r_ready;
    assign bus.Busy     = r_busy;
    assign bus.Conflict = r_conflict;
    assign bus.AddrErr  = r_addrerr;

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: directed table plus random transactions against a word-level memory model.
module tb_mem_responder;
    localparam int DW    = 32;
    localparam int AW    = 9;
    localparam int DEPTH = 256;
    localparam int WS    = 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mem_responder_if #(.DATA_W(DW), .ADDR_W(AW)) bus();

    mem_responder #(
        .DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH), .WAIT_STATES(WS)
    ) dut (
        .Clock(clk),
        .Reset(rst),
        .bus(bus)
    );

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] ref_mem [DEPTH];
    bit            ref_vld [DEPTH];
    logic [DW-1:0] last_dout = '0;

    typedef struct {
        bit            wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] din;
        logic [DW-1:0] exp_dout;
        bit            exp_err;
    } vec_t;

    vec_t vt [11];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(string name, logic [DW-1:0] got, logic [DW-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
        end
    endtask

    // Word-level memory behaviour: what a completed access must return.
    function automatic void model_access(bit wr, logic [AW-1:0] a, logic [DW-1:0] d,
                                         output logic [DW-1:0] exp_dout, output bit exp_err);
        exp_err = (int'(a) >= DEPTH);
        if (wr) begin
            if (!exp_err) begin
                ref_mem[a[7:0]] = d;
                ref_vld[a[7:0]] = 1'b1;
            end
            exp_dout = last_dout;
        end else begin
            exp_dout  = exp_err ? '0 : ref_mem[a[7:0]];
            last_dout = exp_dout;
        end
    endfunction

    // Strobes already driven for a valid request with the DUT idle.
    task automatic wait_done(string name, logic [AW-1:0] a, int hold,
                             logic [DW-1:0] exp_dout, bit exp_err);
        int n;
        tick();
        chk({name, "/busy_after_accept"}, 32'(bus.Busy), 32'd1);
        chk({name, "/conflict_after_accept"}, 32'(bus.Conflict), 32'd0);
        bus.DataIn  = 32'hDEADBEEF;
        bus.Address = ~a;
        n = 0;
        do begin
            tick();
            n++;
        end while (!bus.Ready && n < 20);
        chk({name, "/latency"}, 32'(n), 32'(WS + 1));
        chk({name, "/busy_at_ready"}, 32'(bus.Busy), 32'd0);
        chk({name, "/dout"}, bus.DataOut, exp_dout);
        chk({name, "/addrerr"}, 32'(bus.AddrErr), 32'(exp_err));
        for (int h = 0; h < hold; h++) begin
            tick();
            chk({name, "/ready_held"}, 32'(bus.Ready), 32'd1);
            chk({name, "/no_second_access"}, 32'(bus.Busy), 32'd0);
        end
        bus.Read  = 1'b0;
        bus.Write = 1'b0;
        tick();
        chk({name, "/ready_drop"}, 32'(bus.Ready), 32'd0);
        chk({name, "/dout_holds"}, bus.DataOut, exp_dout);
    endtask

    task automatic run_req(string name, bit wr, logic [AW-1:0] a, logic [DW-1:0] d, int hold);
        logic [DW-1:0] ed;
        bit            ee;
        model_access(wr, a, d, ed, ee);
        bus.Read    = ~wr;
        bus.Write   = wr;
        bus.Address = a;
        bus.DataIn  = d;
        wait_done(name, a, hold, ed, ee);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, checks %0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        vt[0]  = '{1'b1, 9'h005, 32'h12345678, 32'h00000000, 1'b0};
        vt[1]  = '{1'b0, 9'h005, 32'h00000000, 32'h12345678, 1'b0};
        vt[2]  = '{1'b1, 9'h010, 32'h11111111, 32'h12345678, 1'b0};
        vt[3]  = '{1'b1, 9'h020, 32'hCAFEF00D, 32'h12345678, 1'b0};
        vt[4]  = '{1'b0, 9'h1FF, 32'h00000000, 32'h00000000, 1'b1};
        vt[5]  = '{1'b0, 9'h020, 32'h00000000, 32'hCAFEF00D, 1'b0};
        vt[6]  = '{1'b1, 9'h0FF, 32'hFFFF0000, 32'hCAFEF00D, 1'b0};
        vt[7]  = '{1'b0, 9'h0FF, 32'h00000000, 32'hFFFF0000, 1'b0};
        vt[8]  = '{1'b1, 9'h100, 32'h0BADF00D, 32'hFFFF0000, 1'b1};
        vt[9]  = '{1'b0, 9'h100, 32'h00000000, 32'h00000000, 1'b1};
        vt[10] = '{1'b0, 9'h010, 32'h00000000, 32'h11111111, 1'b0};

        rst         = 1'b1;
        bus.Read    = 1'b0;
        bus.Write   = 1'b0;
        bus.Address = '0;
        bus.DataIn  = '0;
        tick();
        tick();
        chk("reset/dout", bus.DataOut, 32'd0);
        chk("reset/ready", 32'(bus.Ready), 32'd0);
        chk("reset/busy", 32'(bus.Busy), 32'd0);
        chk("reset/conflict", 32'(bus.Conflict), 32'd0);
        chk("reset/addrerr", 32'(bus.AddrErr), 32'd0);

        // First read straight out of reset, also an out-of-range address.
        rst = 1'b0;
        run_req("first_read", 1'b0, 9'h1FF, 32'h0, 0);

        for (int i = 0; i < 11; i++) begin
            logic [DW-1:0] ed;
            bit            ee;
            model_access(vt[i].wr, vt[i].addr, vt[i].din, ed, ee);
            bus.Read    = ~vt[i].wr;
            bus.Write   = vt[i].wr;
            bus.Address = vt[i].addr;
            bus.DataIn  = vt[i].din;
            wait_done($sformatf("vec%0d", i), vt[i].addr, i % 3, vt[i].exp_dout, vt[i].exp_err);
        end

        // Write strobe held 5 cycles; DataIn swaps to DEADBEEF after accept.
        run_req("held_write", 1'b1, 9'h030, 32'h0000C0DE, 1);
        run_req("held_write_rb", 1'b0, 9'h030, 32'h0, 0);
        chk("held_write/value", bus.DataOut, 32'h0000C0DE);

        // Both strobes in IDLE: nothing accepted until Write drops.
        bus.Read    = 1'b1;
        bus.Write   = 1'b1;
        bus.Address = 9'h010;
        bus.DataIn  = 32'h77777777;
        tick();
        chk("conflict/flag", 32'(bus.Conflict), 32'd1);
        chk("conflict/busy", 32'(bus.Busy), 32'd0);
        chk("conflict/ready", 32'(bus.Ready), 32'd0);
        tick();
        chk("conflict/flag_hold", 32'(bus.Conflict), 32'd1);
        chk("conflict/busy_hold", 32'(bus.Busy), 32'd0);
        begin
            logic [DW-1:0] ed;
            bit            ee;
            model_access(1'b0, 9'h010, 32'h0, ed, ee);
            bus.Write = 1'b0;
            wait_done("conflict_read", 9'h010, 1, 32'h11111111, 1'b0);
        end

        // Reset lands while a write is still waiting.
        bus.Read    = 1'b0;
        bus.Write   = 1'b1;
        bus.Address = 9'h020;
        bus.DataIn  = 32'hA5A5A5A5;
        tick();
        chk("rst_wait/busy", 32'(bus.Busy), 32'd1);
        tick();
        rst       = 1'b1;
        bus.Write = 1'b0;
        tick();
        chk("rst_wait/ready", 32'(bus.Ready), 32'd0);
        chk("rst_wait/dout", bus.DataOut, 32'd0);
        chk("rst_wait/busy_clr", 32'(bus.Busy), 32'd0);
        rst       = 1'b0;
        last_dout = '0;
        tick();
        run_req("rst_wait_rb", 1'b0, 9'h020, 32'h0, 0);

        for (int t = 0; t < 40; t++) begin
            bit            wr;
            logic [AW-1:0] a;
            logic [DW-1:0] d;
            int            hold;
            int            gap;
            if ($urandom_range(0, 7) == 0) a = 9'($urandom_range(256, 511));
            else                           a = 9'($urandom_range(0, 63));
            wr = 1'($urandom_range(0, 1));
            if (!wr && int'(a) < DEPTH && !ref_vld[a[7:0]]) wr = 1'b1;
            d    = $urandom;
            hold = $urandom_range(0, 3);
            gap  = $urandom_range(0, 2);
            run_req($sformatf("rand%0d", t), wr, a, d, hold);
            for (int g = 0; g < gap; g++) tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
